// File: rtl/symbolic_qkd_pkg.sv
// Shared types and helpers for the symbolic QKD family: slot lifecycle,
// per-slot metadata layout and the obfuscation LFSR step.
package symbolic_qkd_pkg;

  localparam int          LFSR_W    = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Metadata fields are sized for the widest identity/time any instance may
  // use; narrower instances zero-extend, so the constant-zero bits fold away.
  localparam int META_ID_W   = 16;
  localparam int META_TIME_W = 16;

  typedef enum logic [1:0] {
    EMPTY,
    ARMED,
    COLLAPSED
  } slot_state_e;

  typedef struct packed {
    logic [1:0]             basis;
    logic [1:0]             phase;
    logic [META_ID_W-1:0]   id;
    logic [META_TIME_W-1:0] t_start;
    logic [META_TIME_W-1:0] t_end;
  } slot_meta_t;

  // One Fibonacci step: shift left, feed the tap parity into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/symbolic_qkd_bank_if.sv
// Init / read / tamper bundle between the key-distribution controller and
// the slot bank. The controller side is master, the bank is slave.
interface symbolic_qkd_bank_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int ID_W      = 4,
  parameter int TIME_W    = 8
);
  logic                 init;
  logic [SLOT_W-1:0]    init_slot;
  logic [ID_W-1:0]      init_id;
  logic [TIME_W-1:0]    init_t_start;
  logic [TIME_W-1:0]    init_t_end;
  logic                 read;
  logic [SLOT_W-1:0]    read_slot;
  logic [1:0]           basis_in;
  logic [1:0]           phase_in;
  logic [ID_W-1:0]      identity_in;
  logic [TIME_W-1:0]    time_in;
  logic                 fuse_blow;
  logic [DATA_W-1:0]    value_out;
  logic                 output_enable;
  logic                 pad_enable;
  logic                 fuse_fire;
  logic                 init_reject;
  logic [NUM_SLOTS-1:0] armed_mask;
  logic                 fuse_blown;

  modport master (
    output init, init_slot, init_id, init_t_start, init_t_end,
    output read, read_slot, basis_in, phase_in, identity_in, time_in,
    output fuse_blow,
    input  value_out, output_enable, pad_enable, fuse_fire, init_reject,
    input  armed_mask, fuse_blown
  );

  modport slave (
    input  init, init_slot, init_id, init_t_start, init_t_end,
    input  read, read_slot, basis_in, phase_in, identity_in, time_in,
    input  fuse_blow,
    output value_out, output_enable, pad_enable, fuse_fire, init_reject,
    output armed_mask, fuse_blown
  );
endinterface

// File: rtl/qkd_slot.sv
// One read-once secret: lifecycle FSM, stored value, randomised tags and
// identity/time policy, plus its own authorisation term for the current read.
module qkd_slot
  import symbolic_qkd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W+3:0] rnd,          // low LFSR bits: value, basis, phase
  input  logic              arm,          // init accepted for this slot
  input  logic              read_hit,     // a read addresses this slot
  input  logic              kill,         // global tamper, now or latched
  input  logic [ID_W-1:0]   init_id,
  input  logic [TIME_W-1:0] init_t_start,
  input  logic [TIME_W-1:0] init_t_end,
  input  logic [1:0]        basis_in,
  input  logic [1:0]        phase_in,
  input  logic [ID_W-1:0]   identity_in,
  input  logic [TIME_W-1:0] time_in,
  output logic              armed,
  output logic              authorised,
  output logic [DATA_W-1:0] value
);

  slot_state_e state_q, state_d;
  slot_meta_t  meta_q;
  logic        collapse;
  logic [META_TIME_W-1:0] now;

  assign armed    = (state_q == ARMED);
  assign collapse = armed & read_hit;
  assign now      = META_TIME_W'(time_in);

  // An inverted window can never satisfy both bounds, so it never authorises.
  assign authorised = armed
                    & (basis_in == meta_q.basis)
                    & (phase_in == meta_q.phase)
                    & (META_ID_W'(identity_in) == meta_q.id)
                    & (now >= meta_q.t_start)
                    & (now <= meta_q.t_end);

  // Lifecycle state register.
  // NOTE: clocked state always uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: tamper dominates, a read collapses, an accepted init arms.
  // NOTE: hold-by-default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        ARMED:   if (read_hit) state_d = COLLAPSED;
        default: if (arm)      state_d = ARMED;
      endcase
    end
  end

  // Secret and metadata: captured on arm, scrambled on collapse or tamper.
  // NOTE: value and tags are reset too, so no secret survives a reset cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value  <= '0;
      meta_q <= '0;
    end else if (kill || collapse) begin
      value  <= rnd[DATA_W-1:0];
    end else if (arm) begin
      value          <= rnd[DATA_W-1:0];
      meta_q.basis   <= rnd[DATA_W+1:DATA_W];
      meta_q.phase   <= rnd[DATA_W+3:DATA_W+2];
      meta_q.id      <= META_ID_W'(init_id);
      meta_q.t_start <= META_TIME_W'(init_t_start);
      meta_q.t_end   <= META_TIME_W'(init_t_end);
    end
  end

endmodule

// File: rtl/symbolic_qkd_bank.sv
// Multi-slot symbolic QKD bank: free-running obfuscation LFSR, slot decode,
// read mux and registered release / collapse / reject pulses.
module symbolic_qkd_bank
  import symbolic_qkd_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          NUM_SLOTS = 4,
  parameter int          SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int          ID_W      = 4,
  parameter int          TIME_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               reset,
  symbolic_qkd_bank_if.slave bus
);

  logic [LFSR_W-1:0]    lfsr_q;
  logic                 fuse_blown_q;
  logic                 kill;
  logic [NUM_SLOTS-1:0] armed, auth, read_hit, arm;
  logic [DATA_W-1:0]    slot_value [NUM_SLOTS];

  logic                 read_valid, init_valid;
  logic                 armed_at_init, armed_at_read, auth_at_read;
  logic [DATA_W-1:0]    value_at_read;
  logic                 init_accept, release_now, fire_now;

  logic [DATA_W-1:0]    value_q;
  logic                 enable_q, fire_q, reject_q;

  assign kill       = bus.fuse_blow | fuse_blown_q;
  assign read_valid = bus.read & ({1'b0, bus.read_slot} < (SLOT_W+1)'(NUM_SLOTS));
  assign init_valid = bus.init & ({1'b0, bus.init_slot} < (SLOT_W+1)'(NUM_SLOTS));

  // Free-running obfuscation source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  // Sticky tamper flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              fuse_blown_q <= 1'b0;
    else if (bus.fuse_blow) fuse_blown_q <= 1'b1;
  end

  // Select the addressed slot's status and value for init and read.
  always_comb begin
    armed_at_init = 1'b0;
    armed_at_read = 1'b0;
    auth_at_read  = 1'b0;
    value_at_read = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.init_slot == SLOT_W'(i)) armed_at_init = armed[i];
      if (bus.read_slot == SLOT_W'(i)) begin
        armed_at_read = armed[i];
        auth_at_read  = auth[i];
        value_at_read = slot_value[i];
      end
    end
  end

  // An armed target (even one collapsing this very edge) refuses the init.
  assign init_accept = init_valid & ~fuse_blown_q & ~armed_at_init;
  assign release_now = read_valid & auth_at_read & ~kill;
  assign fire_now    = read_valid & armed_at_read & ~fuse_blown_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign read_hit[g] = read_valid  & (bus.read_slot == SLOT_W'(g));
    assign arm[g]      = init_accept & (bus.init_slot == SLOT_W'(g));

    qkd_slot #(
      .DATA_W (DATA_W),
      .ID_W   (ID_W),
      .TIME_W (TIME_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .rnd          (lfsr_q[DATA_W+3:0]),
      .arm          (arm[g]),
      .read_hit     (read_hit[g]),
      .kill         (kill),
      .init_id      (bus.init_id),
      .init_t_start (bus.init_t_start),
      .init_t_end   (bus.init_t_end),
      .basis_in     (bus.basis_in),
      .phase_in     (bus.phase_in),
      .identity_in  (bus.identity_in),
      .time_in      (bus.time_in),
      .armed        (armed[g]),
      .authorised   (auth[g]),
      .value        (slot_value[g])
    );
  end

  // Registered outputs: true value only on an authorised read, else noise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q  <= '0;
      enable_q <= 1'b0;
      fire_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      value_q  <= release_now ? value_at_read : lfsr_q[DATA_W-1:0];
      enable_q <= release_now;
      fire_q   <= fire_now;
      reject_q <= bus.init & ~init_accept;
    end
  end

  assign bus.value_out     = value_q;
  assign bus.output_enable = enable_q;
  assign bus.pad_enable    = enable_q & ~fuse_blown_q;
  assign bus.fuse_fire     = fire_q;
  assign bus.init_reject   = reject_q;
  assign bus.armed_mask    = armed;
  assign bus.fuse_blown    = fuse_blown_q;

endmodule

// File: tb/tb_symbolic_qkd_bank.sv
// Bench for symbolic_qkd_bank: a default 8-bit/4-slot instance and a
// 12-bit/3-slot instance, both checked every cycle against a slot-array model.
module tb_symbolic_qkd_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       init;
    logic [3:0] init_slot;
    logic [3:0] init_id;
    logic [7:0] ts;
    logic [7:0] te;
    logic       read;
    logic [3:0] read_slot;
    logic [1:0] basis;
    logic [1:0] phase;
    logic [3:0] ident;
    logic [7:0] t;
    logic       blow;
  } stim_t;

  stim_t st [2];

  symbolic_qkd_bank_if #(.DATA_W(8),  .NUM_SLOTS(4), .SLOT_W(2), .ID_W(4), .TIME_W(8)) b0 ();
  symbolic_qkd_bank_if #(.DATA_W(12), .NUM_SLOTS(3), .SLOT_W(2), .ID_W(4), .TIME_W(8)) b1 ();

  symbolic_qkd_bank #(.DATA_W(8),  .NUM_SLOTS(4), .SLOT_W(2), .ID_W(4), .TIME_W(8),
                      .LFSR_SEED(16'hACE1)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  symbolic_qkd_bank #(.DATA_W(12), .NUM_SLOTS(3), .SLOT_W(2), .ID_W(4), .TIME_W(8),
                      .LFSR_SEED(16'hACE1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));

  assign b0.init = st[0].init;          assign b1.init = st[1].init;
  assign b0.init_slot = st[0].init_slot[1:0]; assign b1.init_slot = st[1].init_slot[1:0];
  assign b0.init_id = st[0].init_id;    assign b1.init_id = st[1].init_id;
  assign b0.init_t_start = st[0].ts;    assign b1.init_t_start = st[1].ts;
  assign b0.init_t_end = st[0].te;      assign b1.init_t_end = st[1].te;
  assign b0.read = st[0].read;          assign b1.read = st[1].read;
  assign b0.read_slot = st[0].read_slot[1:0]; assign b1.read_slot = st[1].read_slot[1:0];
  assign b0.basis_in = st[0].basis;     assign b1.basis_in = st[1].basis;
  assign b0.phase_in = st[0].phase;     assign b1.phase_in = st[1].phase;
  assign b0.identity_in = st[0].ident;  assign b1.identity_in = st[1].ident;
  assign b0.time_in = st[0].t;          assign b1.time_in = st[1].t;
  assign b0.fuse_blow = st[0].blow;     assign b1.fuse_blow = st[1].blow;

  // Reference model: per-slot arrays driven straight from the slot rules.
  int NS [2] = '{4, 3};
  int DW [2] = '{8, 12};
  int m_armed [2][16];
  int m_val   [2][16];
  int m_basis [2][16];
  int m_phase [2][16];
  int m_id    [2][16];
  int m_ts    [2][16];
  int m_te    [2][16];
  int m_blown [2];
  int m_lfsr;
  int e_val [2], e_oe [2], e_fire [2], e_rej [2];

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 16; s++) begin
        m_armed[d][s] = 0; m_val[d][s] = 0; m_basis[d][s] = 0; m_phase[d][s] = 0;
        m_id[d][s] = 0; m_ts[d][s] = 0; m_te[d][s] = 0;
      end
      m_blown[d] = 0; e_val[d] = 0; e_oe[d] = 0; e_fire[d] = 0; e_rej[d] = 0;
    end
    m_lfsr = 'hACE1;
  endtask

  function automatic int mask(int d);
    int m = 0;
    for (int s = 0; s < NS[d]; s++) if (m_armed[d][s] != 0) m |= (1 << s);
    return m;
  endfunction

  task automatic model_step(int d);
    int  dw    = DW[d];
    int  noise = m_lfsr & ((1 << dw) - 1);
    int  rs    = int'(st[d].read_slot);
    int  is    = int'(st[d].init_slot);
    bit  rd    = st[d].read && rs < NS[d];
    bit  in_ok = st[d].init && is < NS[d];
    bit  ra    = rd && m_armed[d][rs] != 0;
    bit  auth;
    bit  accept;
    auth = ra && m_blown[d] == 0 && !st[d].blow
        && int'(st[d].basis) == m_basis[d][rs] && int'(st[d].phase) == m_phase[d][rs]
        && int'(st[d].ident) == m_id[d][rs]
        && m_ts[d][rs] <= int'(st[d].t) && int'(st[d].t) <= m_te[d][rs];
    accept   = in_ok && m_blown[d] == 0 && m_armed[d][is] == 0;
    e_oe[d]  = auth ? 1 : 0;
    e_val[d] = auth ? m_val[d][rs] : noise;
    e_fire[d] = (ra && m_blown[d] == 0) ? 1 : 0;
    e_rej[d] = (st[d].init && !accept) ? 1 : 0;
    if (st[d].blow || m_blown[d] != 0) begin
      m_blown[d] = 1;
      for (int s = 0; s < 16; s++) m_armed[d][s] = 0;
    end else begin
      if (ra) m_armed[d][rs] = 0;
      if (accept) begin
        m_armed[d][is] = 1;
        m_val[d][is]   = noise;
        m_basis[d][is] = (m_lfsr >> dw) & 3;
        m_phase[d][is] = (m_lfsr >> (dw + 2)) & 3;
        m_id[d][is]    = int'(st[d].init_id);
        m_ts[d][is]    = int'(st[d].ts);
        m_te[d][is]    = int'(st[d].te);
      end
    end
  endtask

  task automatic lfsr_step();
    int fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) & 'hFFFF) | fb;
  endtask

  task automatic compare_dut(int d, logic [31:0] v, logic [31:0] oe, logic [31:0] pe,
                             logic [31:0] ff, logic [31:0] rj, logic [31:0] am,
                             logic [31:0] fb);
    check($sformatf("d%0d_value", d),  v,  e_val[d]);
    check($sformatf("d%0d_oe", d),     oe, e_oe[d]);
    check($sformatf("d%0d_pad", d),    pe, e_oe[d]);
    check($sformatf("d%0d_fire", d),   ff, e_fire[d]);
    check($sformatf("d%0d_reject", d), rj, e_rej[d]);
    check($sformatf("d%0d_armed", d),  am, mask(d));
    check($sformatf("d%0d_blown", d),  fb, m_blown[d]);
  endtask

  task automatic compare_all();
    compare_dut(0, 32'(b0.value_out), 32'(b0.output_enable), 32'(b0.pad_enable),
                32'(b0.fuse_fire), 32'(b0.init_reject), 32'(b0.armed_mask), 32'(b0.fuse_blown));
    compare_dut(1, 32'(b1.value_out), 32'(b1.output_enable), 32'(b1.pad_enable),
                32'(b1.fuse_fire), 32'(b1.init_reject), 32'(b1.armed_mask), 32'(b1.fuse_blown));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    lfsr_step();
    #1;
    compare_all();
    for (int d = 0; d < 2; d++) begin
      st[d].init = 1'b0; st[d].read = 1'b0; st[d].blow = 1'b0;
    end
  endtask

  task automatic arm(int d, int slot, int id, int ts, int te);
    st[d].init = 1'b1; st[d].init_slot = 4'(slot); st[d].init_id = 4'(id);
    st[d].ts = 8'(ts); st[d].te = 8'(te);
  endtask

  task automatic rd(int d, int slot, int b, int p, int id, int t);
    st[d].read = 1'b1; st[d].read_slot = 4'(slot); st[d].basis = 2'(b);
    st[d].phase = 2'(p); st[d].ident = 4'(id); st[d].t = 8'(t);
  endtask

  task automatic rd_good(int d, int slot, int t);
    rd(d, slot, m_basis[d][slot], m_phase[d][slot], m_id[d][slot], t);
  endtask

  initial begin
    reset = 1'b1;
    st[0] = '0;
    st[1] = '0;
    model_reset();
    #12;
    compare_all();

    // First cycle out of reset: arm with the seed as the LFSR value.
    arm(0, 0, 'hA, 10, 200);
    arm(1, 0, 5, 0, 255);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    rd(0, 0, 0, 3, 'hA, 50);
    rd_good(1, 0, 100);
    cycle();
    check("tp_value8", 32'(b0.value_out), 32'hE1);
    check("tp_oe8", 32'(b0.output_enable), 1);
    check("tp_value12", 32'(b1.value_out), 32'hCE1);

    // Wrong basis collapses without release; a later correct read gets nothing.
    arm(0, 1, 3, 0, 255);
    cycle();
    rd(0, 1, m_basis[0][1] ^ 1, m_phase[0][1], 3, 7);
    cycle();
    check("wrong_basis_fire", 32'(b0.fuse_fire), 1);
    rd_good(0, 1, 7);
    cycle();
    check("second_read_fire", 32'(b0.fuse_fire), 0);

    // Window edges on a re-armed slot 0.
    arm(0, 0, 'hA, 10, 200); cycle(); rd_good(0, 0, 9);   cycle();
    check("win9_oe", 32'(b0.output_enable), 0);
    arm(0, 0, 'hA, 10, 200); cycle(); rd_good(0, 0, 10);  cycle();
    check("win10_oe", 32'(b0.output_enable), 1);
    arm(0, 0, 'hA, 10, 200); cycle(); rd_good(0, 0, 200); cycle();
    check("win200_oe", 32'(b0.output_enable), 1);
    arm(0, 0, 'hA, 10, 200); cycle(); rd_good(0, 0, 201); cycle();
    check("win201_oe", 32'(b0.output_enable), 0);
    check("win201_fire", 32'(b0.fuse_fire), 1);

    // Inverted window never authorises.
    arm(0, 1, 2, 20, 10); cycle(); rd_good(0, 1, 15); cycle();
    check("inverted_oe", 32'(b0.output_enable), 0);

    // Read beats a coincident init on an armed slot.
    arm(0, 2, 6, 0, 255); cycle();
    rd_good(0, 2, 1); arm(0, 2, 6, 0, 255); cycle();
    check("rw_same_reject", 32'(b0.init_reject), 1);

    // Overwrite attempt on armed slot 3 must leave its tags intact.
    arm(0, 3, 7, 0, 255); cycle();
    arm(0, 3, 9, 0, 255); cycle();
    check("overwrite_reject", 32'(b0.init_reject), 1);
    rd_good(0, 3, 100); cycle();
    check("overwrite_kept_oe", 32'(b0.output_enable), 1);

    // Out-of-range slot on the 3-slot instance.
    rd(1, 3, 0, 0, 0, 0); arm(1, 3, 1, 0, 255); cycle();
    check("oor_reject", 32'(b1.init_reject), 1);
    check("oor_fire", 32'(b1.fuse_fire), 0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(2) == 0)
          arm(d, $urandom_range(3), $urandom_range(3), $urandom_range(31), $urandom_range(31));
        if ($urandom_range(1) == 1) begin
          int slot = $urandom_range(3);
          if ($urandom_range(1) == 1) rd_good(d, slot, $urandom_range(31));
          else rd(d, slot, $urandom_range(3), $urandom_range(3), $urandom_range(3),
                  $urandom_range(31));
        end
      end
      cycle();
    end

    // Tamper with every slot of instance 0 armed; coincident read releases nothing.
    for (int s = 0; s < 4; s++) if (m_armed[0][s] == 0) begin
      arm(0, s, 1, 0, 255);
      cycle();
    end
    check("all_armed", 32'(b0.armed_mask), 32'hF);
    st[0].blow = 1'b1;
    rd_good(0, 3, 100);
    cycle();
    check("blow_oe", 32'(b0.output_enable), 0);
    check("blow_flag", 32'(b0.fuse_blown), 1);
    arm(0, 0, 1, 0, 255); cycle();
    check("blown_init_reject", 32'(b0.init_reject), 1);
    rd_good(0, 0, 5); cycle();
    check("blown_read_fire", 32'(b0.fuse_fire), 0);

    // Asynchronous reset mid-operation, then the seed sequence repeats.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    arm(0, 0, 'hA, 10, 200);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    rd(0, 0, 0, 3, 'hA, 50);
    cycle();
    check("post_reset_value", 32'(b0.value_out), 32'hE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbolic_qkd_bank.md
Name: symbolic_qkd_bank

Overview:
Parametrised multi-slot successor of the single symbolic QKD register. Holds NUM_SLOTS independent read-once secrets, each with randomised basis/phase tags and a per-slot identity and time-window policy loaded at init. Any read of an armed slot collapses it, whether or not its metadata match. Only a fully authorised read releases the true value, once, on a registered output. Sits between the symbolic key-distribution controller and the pad/OTP fuse interface.

Parameters:
DATA_W, 8, secret width in bits; legal range 1..12.
NUM_SLOTS, 4, number of independent slots; legal range 1..16.
SLOT_W, $clog2(NUM_SLOTS) (minimum 1), slot index width.
ID_W, 4, identity width.
TIME_W, 8, time stamp width.
LFSR_SEED, 16'hACE1, reset value of the obfuscation LFSR; must be non-zero.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high.
init  in  1  one-cycle strobe: arm slot init_slot.
init_slot  in  SLOT_W  slot to arm.
init_id  in  ID_W  authorised identity for that slot.
init_t_start  in  TIME_W  start of the slot's valid time window (inclusive).
init_t_end  in  TIME_W  end of the slot's valid time window (inclusive).
read  in  1  one-cycle read strobe.
read_slot  in  SLOT_W  slot to read.
basis_in  in  2  reader basis.
phase_in  in  2  reader phase.
identity_in  in  ID_W  reader identity.
time_in  in  TIME_W  current time.
fuse_blow  in  1  global tamper; permanently kills every slot.
value_out  out  DATA_W  registered; true value or noise.
output_enable  out  1  registered 1-cycle pulse: value_out is the true value.
pad_enable  out  1  equals output_enable gated by ~fuse_blown.
fuse_fire  out  1  registered 1-cycle pulse on every collapse.
init_reject  out  1  registered 1-cycle pulse: the init strobe was ignored.
armed_mask  out  NUM_SLOTS  bit i = slot i is ARMED.
fuse_blown  out  1  sticky global kill flag.

Behaviour:
- LFSR: 16-bit Fibonacci, free-running; update lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; reset value LFSR_SEED.
- Reset values: all outputs 0, lfsr = LFSR_SEED, every slot EMPTY, stored values and tags 0, fuse_blown = 0.
- Per-slot FSM, states EMPTY / ARMED / COLLAPSED; KILLED applies to all slots once fuse_blown = 1.
- EMPTY or COLLAPSED -> ARMED on an accepted init. On that edge, from the pre-edge lfsr:
  - stored = lfsr[DATA_W-1:0]
  - basis = lfsr[DATA_W+1:DATA_W]
  - phase = lfsr[DATA_W+3:DATA_W+2]
  - the slot latches init_id, init_t_start, init_t_end.
  - Re-arming a COLLAPSED slot is allowed. This is new behaviour.
- ARMED -> COLLAPSED on any read of that slot. On that edge:
  - stored is wiped to the current lfsr value.
  - fuse_fire pulses on the next cycle.
- Authorised read: slot ARMED, basis, phase and identity all equal the slot's values, and t_start <= time_in <= t_end (unsigned).
- Output latency is 1 cycle:
  - Authorised read: value_out = stored value, output_enable = 1, pad_enable = 1.
  - Any other cycle: value_out = the pre-edge lfsr[DATA_W-1:0], output_enable = 0.
- Reads of an EMPTY or COLLAPSED slot, or with read_slot >= NUM_SLOTS: noise only; no state change and no fuse_fire.
- An inverted window (t_start > t_end) is accepted, but no read of that slot can ever authorise.
- Simultaneous read and init on the same slot:
  - The read is evaluated against the pre-edge state.
  - If the slot was ARMED, the read wins: the slot collapses and init_reject pulses.
  - If the slot was EMPTY or COLLAPSED, the init is accepted.
- Read and init on different slots in the same cycle are fully independent.
- Init is rejected (init_reject pulses, no state change) when:
  - the target slot is currently ARMED (no overwrite), or
  - init_slot >= NUM_SLOTS, or
  - fuse_blown = 1.
- fuse_blow:
  - Sets fuse_blown on the next edge; only reset clears it.
  - Clears armed_mask and wipes every stored value to lfsr.
  - While fuse_blown = 1, output_enable and pad_enable are 0 and reads do not pulse fuse_fire.
  - If a read coincides with fuse_blow, no value is released.
- Reset mid-operation returns everything to the reset values immediately (asynchronous).

Decomposition:
- Package symbolic_qkd_pkg holds:
  - slot_state_e {EMPTY, ARMED, COLLAPSED}
  - slot_meta_t struct {basis, phase, id, t_start, t_end}
  - LFSR_TAPS constant
  - lfsr_next() function, shared with the other symbolic-QKD modules.
- Sub-module qkd_slot (one per slot, generate loop):
  - holds one slot's state, value and metadata
  - computes its own hit/authorised term.
- Top level holds the LFSR, decode, output mux and output registers.

Test Plan:
- Reset, then in the first cycle init slot 0 (id 4'hA, window 10..200) with lfsr = 16'hACE1. Next cycle read slot 0 with basis 0, phase 3, id A, time 50 -> one cycle later value_out = 8'hE1, output_enable = 1, pad_enable = 1, fuse_fire = 1, armed_mask[0] = 0.
- Arm slot 1, then read it with the wrong basis -> output_enable = 0, value_out = LFSR noise, fuse_fire = 1. A second, correct read -> output_enable = 0 and fuse_fire = 0.
- Time boundaries: window 10..200. time_in 9 -> denied. Re-arm and read at 10 -> released. Re-arm and read at 200 -> released. Re-arm and read at 201 -> denied. Every read pulses fuse_fire.
- Init of slot 2 in the same cycle as a read of armed slot 2 -> the slot collapses and init_reject = 1. Init of an ARMED slot 3 -> init_reject = 1 and slot 3's tags are unchanged.
- Pulse fuse_blow with slots 0..3 armed -> fuse_blown = 1, armed_mask = 0. A later init -> init_reject = 1. A later read -> no output_enable and no fuse_fire. Assert reset -> all cleared.
- With NUM_SLOTS = 3, read_slot = 3 or init_slot = 3 -> noise / init_reject, no state change. Also cover a regression run with DATA_W = 12, NUM_SLOTS = 16.
